// File: rtl/wisc_pkg.sv
// Shared constants and types for the WISC fetch path.
package wisc_pkg;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;
  localparam logic [3:0]  OPC_HLT = 4'hF;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT,
    FS_HALT
  } fetch_state_t;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO between instruction memory returns and IF/ID; flush beats push/pop.
module fetch_buf
  import wisc_pkg::*;
#(
  parameter int unsigned DATA_W = ADDR_W + INSTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  // Empty buffer presents zeros so the IF/ID side never sees stale data.
  assign head_data = (count_q != 2'd0) ? mem[rd_ptr] : '0;
  assign count     = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, single-outstanding imem request, redirect/squash, HLT stop.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = wisc_pkg::ADDR_W,
  parameter int unsigned       INSTR_W  = wisc_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc_plus2,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);
  import wisc_pkg::*;

  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus2;
  logic kill_q, kill_d;
  logic br_eff, accept, push, pop;
  logic [1:0] count;
  logic [INSTR_W+ADDR_W-1:0] head;

  assign pc_plus2  = pc_q + ADDR_W'(2);
  assign br_eff    = br_taken && (state_q != FS_IDLE);
  // Holding off while kill is set keeps a single request in flight to memory.
  assign imem_req  = (state_q == FS_REQ) && (count <= 2'd1) && !kill_q;
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;
  assign push      = imem_valid && (state_q == FS_WAIT) && !br_eff;
  assign pop       = if_valid && !stall;

  fetch_buf #(.DATA_W(INSTR_W + ADDR_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({imem_data, pc_plus2}),
    .pop       (pop),
    .flush     (br_eff),
    .head_data (head),
    .count     (count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    unique case (state_q)
      FS_IDLE: state_d = FS_REQ;
      FS_REQ:  if (accept) state_d = FS_WAIT;
      FS_WAIT: if (imem_valid) begin
        pc_d    = pc_plus2;
        state_d = (imem_data[INSTR_W-1 -: 4] == OPC_HLT) ? FS_HALT : FS_REQ;
      end
      FS_HALT: state_d = FS_HALT;
    endcase
    if (imem_valid && kill_q) kill_d = 1'b0;
    // A request still in flight after a redirect must have its return squashed.
    if (br_eff) begin
      pc_d    = br_target & ~ADDR_W'(1);
      state_d = FS_REQ;
      kill_d  = accept || ((state_q == FS_WAIT || kill_q) && !imem_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  assign if_valid    = (count != 2'd0);
  assign if_instr    = head[INSTR_W+ADDR_W-1 -: INSTR_W];
  assign if_pc_plus2 = head[ADDR_W-1:0];
  assign pc          = pc_q;
  assign halted      = (state_q == FS_HALT) && (count == 2'd0);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a queue-level fetch/memory model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic [15:0] pc;
  logic        halted;

  fetch_sequencer #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc_plus2 (if_pc_plus2),
    .pc          (pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc2;
  } ent_t;

  ent_t        m_q[$];
  ent_t        log_q[$];
  logic [15:0] m_pc;
  bit          m_kill, m_halt, m_idle;
  bit          mem_busy;
  int          mem_lat;
  int          lat_cfg;
  logic [15:0] mem_addr;
  logic [15:0] hlt_addr;
  bit          armed;
  int          n_tests;
  int          n_fail;

  function automatic logic [15:0] mem_func(input logic [15:0] a);
    return (a == hlt_addr) ? 16'hF000 : {3'b001, a[12:0]};
  endfunction

  function automatic bit req_exp();
    return !m_idle && !m_halt && !mem_busy && (m_q.size() <= 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [15:0] pc2,
                         input logic [15:0] instr);
    if (idx < log_q.size()) begin
      chk({name, "_pc2"}, 32'(log_q[idx].pc2), 32'(pc2));
      chk({name, "_instr"}, 32'(log_q[idx].instr), 32'(instr));
    end else begin
      chk({name, "_present"}, 32'(log_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", 32'(imem_req), 32'(req_exp()));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("if_valid", 32'(if_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("if_instr", 32'(if_instr), 32'(m_q[0].instr));
      chk("if_pc_plus2", 32'(if_pc_plus2), 32'(m_q[0].pc2));
    end
    chk("halted", 32'(halted), 32'(m_halt && m_q.size() == 0));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc     = 16'h0000;
    m_kill   = 0;
    m_halt   = 0;
    m_idle   = 1;
    mem_busy = 0;
    mem_lat  = 0;
  endtask

  // One clock: compare, drive inputs, advance the model at the edge.
  task automatic step(input logic st, input logic br, input logic [15:0] tgt,
                      input logic rdy, input logic rst_in, input logic spur);
    bit          vld, req_e, acc;
    logic [15:0] old_pc;
    if (armed) check_outputs();
    req_e      = req_exp();
    vld        = mem_busy && (mem_lat == 0);
    rst        = rst_in;
    stall      = st;
    br_taken   = br;
    br_target  = tgt;
    imem_ready = rdy;
    imem_valid = vld || spur;
    imem_data  = vld ? mem_func(mem_addr) : 16'hF0F0;
    @(posedge clk);
    old_pc = m_pc;
    if (!rst_in) begin
      model_reset();
    end else if (m_idle) begin
      m_idle = 0;
    end else begin
      acc = req_e && rdy;
      if (br) begin
        m_pc   = {tgt[15:1], 1'b0};
        m_q.delete();
        m_halt = 0;
        m_kill = (mem_busy && !vld) || acc;
      end else begin
        if (m_q.size() != 0 && !st) begin
          log_q.push_back(m_q[0]);
          void'(m_q.pop_front());
        end
        if (vld) begin
          if (m_kill) m_kill = 0;
          else begin
            m_q.push_back('{instr: mem_func(mem_addr), pc2: m_pc + 16'd2});
            if (mem_func(mem_addr) >= 16'hF000) m_halt = 1;
            m_pc = m_pc + 16'd2;
          end
        end
      end
      if (vld) mem_busy = 0;
      else if (mem_busy && mem_lat > 0) mem_lat--;
      if (acc) begin
        mem_busy = 1;
        mem_addr = old_pc;
        mem_lat  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end
    end
    @(negedge clk);
    armed = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    n_tests  = 0;
    n_fail   = 0;
    armed    = 0;
    hlt_addr = 16'h0001;
    lat_cfg  = 1;
    model_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_if_instr", 32'(if_instr), 32'h0);
    chk("rst_if_pc_plus2", 32'(if_pc_plus2), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);

    // 1: sequential fetch, 2-cycle memory latency
    log_q.delete();
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1, 0);
    chk_log("t1_e0", 0, 16'h0002, 16'h2000);
    chk_log("t1_e1", 1, 16'h0004, 16'h2002);
    chk_log("t1_e2", 2, 16'h0006, 16'h2004);

    // 2: stall fills the buffer, then drains
    lat_cfg = 0;
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 1, 0);
    chk("t2_req_blocked", 32'(imem_req), 32'h0);
    chk("t2_head_valid", 32'(if_valid), 32'h1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 0);

    // 3: redirect while a request is in flight
    lat_cfg = 2;
    for (int i = 0; i < 40 && !(mem_busy && !m_kill && mem_lat > 0); i++) step(0, 0, 0, 1, 1, 0);
    chk("t3_in_wait", 32'(mem_busy && mem_lat > 0), 32'h1);
    step(0, 1, 16'h0041, 1, 1, 0);
    chk("t3_pc", 32'(pc), 32'h0040);
    base = log_q.size();
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1, 0);
    chk_log("t3_first", base, 16'h0042, 16'h2040);

    // 4: HLT stops fetch, redirect resumes
    lat_cfg  = 1;
    hlt_addr = 16'h0010;
    step(0, 1, 16'h0010, 1, 1, 0);
    for (int i = 0; i < 40 && !halted; i++) step(0, 0, 0, 1, 1, 0);
    chk("t4_halted", 32'(halted), 32'h1);
    chk("t4_no_req", 32'(imem_req), 32'h0);
    chk("t4_pc", 32'(pc), 32'h0012);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0);
    step(0, 1, 16'h0020, 1, 1, 0);
    chk("t4_resume", 32'(halted), 32'h0);
    base = log_q.size();
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1, 0);
    chk_log("t4_first", base, 16'h0022, 16'h2020);

    // 5: wrap at top of memory, then reset mid-transaction
    lat_cfg = 0;
    step(0, 1, 16'hFFFC, 1, 1, 0);
    base = log_q.size();
    for (int i = 0; i < 14; i++) step(0, 0, 0, 1, 1, 0);
    chk_log("t5_fffc", base, 16'hFFFE, 16'h3FFC);
    chk_log("t5_fffe", base + 1, 16'h0000, 16'h3FFE);
    chk_log("t5_wrap", base + 2, 16'h0002, 16'h2000);
    lat_cfg = 3;
    for (int i = 0; i < 20 && !mem_busy; i++) step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    chk("t5_rst_valid", 32'(if_valid), 32'h0);
    chk("t5_rst_pc", 32'(pc), 32'h0);
    chk("t5_rst_req", 32'(imem_req), 32'h0);
    chk("t5_rst_halted", 32'(halted), 32'h0);
    step(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 0);

    // Random traffic
    lat_cfg  = -1;
    hlt_addr = 16'h0100;
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5,
           16'($urandom_range(0, 511)), $urandom_range(0, 99) < 70, 1, 0);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
